// File: rtl/md5_pkg.sv
// Shared constants and FSM state encoding for the multi-lane MD5 match path.
package md5_pkg;
    localparam int DIGEST_W  = 128;
    localparam int MD5_MSG_W = 152;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_REPORT
    } state_t;
endpackage

// File: rtl/md5_tag_fifo.sv
// Synchronous tag FIFO recording the byte position and lane mask of each issued beat.
module md5_tag_fifo #(
    parameter int  WIDTH = 20,
    parameter int  DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/md5_multilane_dispatch.sv
// Issues candidate beats across NUM_LANES md5core lanes, matches returned digests
// against the target hash and reports the lowest-position hit of the run.
module md5_multilane_dispatch
    import md5_pkg::*;
#(
    parameter int  NUM_LANES = 4,
    parameter int  MSG_W     = MD5_MSG_W,
    parameter int  POS_W     = 16,
    parameter int  TAG_DEPTH = 128,
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DIGEST_W-1:0]        target_hash,
    input  logic                       cand_valid,
    output logic                       cand_ready,
    input  logic [NUM_LANES*MSG_W-1:0] cand_msg,
    input  logic [NUM_LANES-1:0]       cand_mask,
    input  logic [POS_W-1:0]           cand_pos,
    input  logic                       cand_last,
    output logic [NUM_LANES*MSG_W-1:0] core_msg,
    output logic [NUM_LANES-1:0]       core_valid,
    input  logic [NUM_LANES*32-1:0]    core_a,
    input  logic [NUM_LANES*32-1:0]    core_b,
    input  logic [NUM_LANES*32-1:0]    core_c,
    input  logic [NUM_LANES*32-1:0]    core_d,
    input  logic [NUM_LANES-1:0]       core_valid_ret,
    output logic                       busy,
    output logic                       done,
    output logic                       match,
    output logic [POS_W-1:0]           match_pos,
    output logic [LANE_W-1:0]          match_lane,
    output logic                       err
);
    localparam int TAG_W = POS_W + NUM_LANES;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    state_t               state;
    state_t               state_next;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [TAG_W-1:0]     tag_head;
    logic [POS_W-1:0]     tag_pos;
    logic [NUM_LANES-1:0] tag_mask;
    logic [NUM_LANES-1:0] hit;
    logic                 hit_any;
    logic [LANE_W-1:0]    hit_lane;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 ret_any;
    logic                 active;
    logic                 drained;

    assign active     = (state != ST_IDLE);
    assign busy       = active;
    assign done       = (state == ST_REPORT);
    assign cand_ready = (state == ST_RUN) && !fifo_full;
    assign accept     = cand_valid && cand_ready;
    assign push       = accept && (cand_mask != '0);
    assign ret_any    = |core_valid_ret;
    // Returns outside a run are dropped without touching the FIFO or err.
    assign pop        = ret_any && active && !fifo_empty;
    assign drained    = (fifo_count == '0) && !ret_any;
    assign {tag_pos, tag_mask} = tag_head;

    md5_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({cand_pos, cand_mask}),
        .dout  (tag_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign hit[g] = pop && core_valid_ret[g] && tag_mask[g] &&
                        ({core_a[g*32 +: 32], core_b[g*32 +: 32],
                          core_c[g*32 +: 32], core_d[g*32 +: 32]} == target_hash);
    end

    always_comb begin
        hit_any  = 1'b0;
        hit_lane = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (hit[i] && !hit_any) begin
                hit_any  = 1'b1;
                hit_lane = LANE_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_RUN;
            ST_RUN:    if (accept && cand_last) state_next = ST_DRAIN;
            ST_DRAIN:  if (drained) state_next = ST_REPORT;
            ST_REPORT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            core_msg   <= '0;
            core_valid <= '0;
            match      <= 1'b0;
            match_pos  <= '0;
            match_lane <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            core_valid <= push ? cand_mask : '0;
            if (push) core_msg <= cand_msg;
            if (state == ST_IDLE && start) begin
                match      <= 1'b0;
                match_pos  <= '0;
                match_lane <= '0;
                err        <= 1'b0;
            end else begin
                if (hit_any && !match) begin
                    match      <= 1'b1;
                    match_pos  <= tag_pos + POS_W'(hit_lane);
                    match_lane <= hit_lane;
                end
                if (active && ret_any && (fifo_empty || core_valid_ret != tag_mask))
                    err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_md5_multilane_dispatch.sv
// Bench for md5_multilane_dispatch: a latency/stall-controlled core model returns each
// lane's low 128 message bits as its digest; a beat-list model predicts the first hit.
`timescale 1ns/1ps
module tb_md5_multilane_dispatch;
    localparam int NL    = 4;
    localparam int MW    = 152;
    localparam int PW    = 16;
    localparam int DEPTH = 32;
    localparam int LAT   = 3;

    typedef struct { logic [NL-1:0] mask; logic [NL*MW-1:0] msg; } issue_t;
    typedef struct { logic [NL-1:0] mask; logic [NL*MW-1:0] msg; int unsigned due; } pend_t;
    typedef struct { logic [PW-1:0] pos; logic [NL-1:0] mask; logic [NL*MW-1:0] msg; } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start;
    logic [127:0]      target;
    logic              cand_valid;
    logic              cand_ready;
    logic [NL*MW-1:0]  cand_msg;
    logic [NL-1:0]     cand_mask;
    logic [PW-1:0]     cand_pos;
    logic              cand_last;
    logic [NL*MW-1:0]  core_msg;
    logic [NL-1:0]     core_valid;
    logic [NL*32-1:0]  core_a, core_b, core_c, core_d;
    logic [NL-1:0]     core_valid_ret;
    logic              busy, done, match, err;
    logic [PW-1:0]     match_pos;
    logic [1:0]        match_lane;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    logic        stall = 1'b0;
    logic        jitter = 1'b0;
    logic [NL-1:0] inject_mask = '0;
    int unsigned inject_req = 0;
    issue_t      obs_q[$];
    pend_t       pend_q[$];
    beat_t       exp_q[$];

    md5_multilane_dispatch #(
        .NUM_LANES (NL),
        .MSG_W     (MW),
        .POS_W     (PW),
        .TAG_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .target_hash    (target),
        .cand_valid     (cand_valid),
        .cand_ready     (cand_ready),
        .cand_msg       (cand_msg),
        .cand_mask      (cand_mask),
        .cand_pos       (cand_pos),
        .cand_last      (cand_last),
        .core_msg       (core_msg),
        .core_valid     (core_valid),
        .core_a         (core_a),
        .core_b         (core_b),
        .core_c         (core_c),
        .core_d         (core_d),
        .core_valid_ret (core_valid_ret),
        .busy           (busy),
        .done           (done),
        .match          (match),
        .match_pos      (match_pos),
        .match_lane     (match_lane),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Core bank stand-in: fixed latency, in-order, optional stall/jitter and injected returns.
    initial begin : core_model
        pend_t       e;
        logic [127:0] dg;
        int unsigned inject_seen;
        inject_seen = 0;
        core_valid_ret = '0;
        core_a = '0; core_b = '0; core_c = '0; core_d = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) done_cnt++;
            core_valid_ret = '0;
            if (!reset) begin
                pend_q.delete();
            end else begin
                if (core_valid != '0) begin
                    pend_q.push_back('{mask: core_valid, msg: core_msg, due: cyc + LAT});
                    obs_q.push_back('{mask: core_valid, msg: core_msg});
                end
                if (inject_req != inject_seen) begin
                    inject_seen = inject_req;
                    core_valid_ret = inject_mask;
                end else if (!stall && !(jitter && $urandom_range(0, 3) == 0) &&
                             pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    e = pend_q.pop_front();
                    core_valid_ret = e.mask;
                    for (int i = 0; i < NL; i++) begin
                        dg = e.msg[i*MW +: 128];
                        core_a[i*32 +: 32] = dg[127:96];
                        core_b[i*32 +: 32] = dg[95:64];
                        core_c[i*32 +: 32] = dg[63:32];
                        core_d[i*32 +: 32] = dg[31:0];
                    end
                end
            end
        end
    end

    function automatic logic [NL*MW-1:0] make_msg(input logic [NL-1:0] hits);
        logic [NL*MW-1:0] m;
        for (int j = 0; j < NL*MW/32; j++) m[j*32 +: 32] = $urandom;
        for (int i = 0; i < NL; i++) if (hits[i]) m[i*MW +: 128] = target;
        return m;
    endfunction

    // Reference: scan accepted beats in order, lanes low to high, first masked lane whose digest hits.
    function automatic void model_hit(output bit hit, output logic [PW-1:0] pos, output logic [1:0] lane);
        hit = 1'b0; pos = '0; lane = '0;
        foreach (exp_q[b]) begin
            for (int i = 0; i < NL; i++) begin
                if (!hit && exp_q[b].mask[i] && exp_q[b].msg[i*MW +: 128] == target) begin
                    hit  = 1'b1;
                    pos  = exp_q[b].pos + PW'(i);
                    lane = 2'(i);
                end
            end
        end
    endfunction

    function automatic int issue_diffs();
        int k = 0;
        int d = 0;
        foreach (exp_q[b]) begin
            if (exp_q[b].mask != '0) begin
                if (k >= obs_q.size()) d++;
                else if (obs_q[k].mask !== exp_q[b].mask || obs_q[k].msg !== exp_q[b].msg) d++;
                k++;
            end
        end
        if (obs_q.size() > k) d += obs_q.size() - k;
        return d;
    endfunction

    task automatic start_run();
        exp_q.delete();
        obs_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [PW-1:0] pos, input logic [NL-1:0] mask,
                             input logic [NL*MW-1:0] msg, input logic last);
        int unsigned w = 0;
        cand_valid = 1'b1; cand_pos = pos; cand_mask = mask; cand_msg = msg; cand_last = last;
        while (!cand_ready && w < 4000) begin @(negedge clk); w++; end
        n_cmp++;
        if (!cand_ready) begin
            n_bad++;
            $display("FAIL beat_accept: pos %h not accepted within %0d cycles", pos, w);
        end else begin
            exp_q.push_back('{pos: pos, mask: mask, msg: msg});
        end
        @(negedge clk);
        cand_valid = 1'b0;
        cand_last  = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        int unsigned w = 0;
        while (!done && w < 4000) begin @(negedge clk); w++; end
        seen = done;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, done, match, err, cand_ready} !== 5'b0) begin n_bad++;
            $display("FAIL reset_flags: got %b want 00000", {busy, done, match, err, cand_ready}); end
        n_cmp++; if (match_pos !== '0 || match_lane !== '0) begin n_bad++;
            $display("FAIL reset_match: got pos %h lane %0d want 0/0", match_pos, match_lane); end
        n_cmp++; if (core_valid !== '0) begin n_bad++;
            $display("FAIL reset_core_valid: got %b want 0000", core_valid); end
        reset = 1'b1;
        @(negedge clk);
        inject_mask = 4'b0101; inject_req++;
        repeat (3) @(negedge clk);
        n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL idle_return: got err %b busy %b want 0/0", err, busy); end
    endtask

    task automatic test_single_hit();
        logic [NL*MW-1:0] m;
        int unsigned d0;
        bit seen;
        start_run();
        m = make_msg(4'b0100);
        send_beat(16'd100, 4'b1111, m, 1'b1);
        n_cmp++; if (core_valid !== 4'b1111 || core_msg !== m) begin n_bad++;
            $display("FAIL issue_latency: got core_valid %b want 1111 (msg equal %0d)", core_valid, core_msg === m); end
        d0 = done_cnt;
        wait_done(seen);
        n_cmp++; if (!seen || done_cnt - d0 !== 1) begin n_bad++;
            $display("FAIL single_done: got seen %0d pulses %0d want 1/1", seen, done_cnt - d0); end
        n_cmp++; if (match !== 1'b1 || match_pos !== 16'd102 || match_lane !== 2'd2) begin n_bad++;
            $display("FAIL single_hit: got %b/%0d/%0d want 1/102/2", match, match_pos, match_lane); end
    endtask

    task automatic test_first_hit();
        bit seen;
        start_run();
        send_beat(16'd0, 4'b1111, make_msg(4'b0000), 1'b0);
        send_beat(16'd4, 4'b1111, make_msg(4'b1000), 1'b0);
        send_beat(16'd8, 4'b1111, make_msg(4'b0001), 1'b1);
        wait_done(seen);
        n_cmp++; if (!seen || match !== 1'b1 || match_pos !== 16'd7 || match_lane !== 2'd3) begin n_bad++;
            $display("FAIL first_hit: got done %0d %b/%0d/%0d want 1 1/7/3", seen, match, match_pos, match_lane); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL first_hit_err: got %b want 0", err); end
    endtask

    task automatic test_wrap();
        bit seen;
        start_run();
        send_beat(16'hFFFE, 4'b1100, make_msg(4'b1001), 1'b1);
        n_cmp++; if (core_valid !== 4'b1100) begin n_bad++;
            $display("FAIL wrap_issue: got core_valid %b want 1100", core_valid); end
        wait_done(seen);
        n_cmp++; if (!seen || match !== 1'b1 || match_pos !== 16'h0001 || match_lane !== 2'd3) begin n_bad++;
            $display("FAIL wrap_hit: got done %0d %b/%h/%0d want 1 1/0001/3", seen, match, match_pos, match_lane); end
    endtask

    task automatic test_fifo_full();
        bit seen, ehit, held;
        logic [PW-1:0] epos;
        logic [1:0] elane;
        logic [NL*MW-1:0] m;
        stall = 1'b1;
        start_run();
        for (int b = 0; b < DEPTH; b++)
            send_beat(PW'(b * 4), 4'($urandom_range(1, 15)),
                      make_msg(($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0), 1'b0);
        n_cmp++; if (cand_ready !== 1'b0) begin n_bad++;
            $display("FAIL full_ready: got %b want 0", cand_ready); end
        m = make_msg(4'b0010);
        cand_valid = 1'b1; cand_pos = PW'(DEPTH * 4); cand_mask = 4'b1111; cand_msg = m; cand_last = 1'b1;
        held = 1'b1;
        repeat (10) begin @(negedge clk); if (cand_ready) held = 1'b0; end
        n_cmp++; if (!held) begin n_bad++; $display("FAIL full_hold: got cand_ready 1 while stalled want 0"); end
        stall = 1'b0;
        send_beat(PW'(DEPTH * 4), 4'b1111, m, 1'b1);
        wait_done(seen);
        model_hit(ehit, epos, elane);
        n_cmp++; if (!seen || match !== ehit || (ehit && (match_pos !== epos || match_lane !== elane))) begin n_bad++;
            $display("FAIL full_match: got done %0d %b/%h/%0d want %b/%h/%0d", seen, match, match_pos, match_lane, ehit, epos, elane); end
        n_cmp++; if (issue_diffs() !== 0 || exp_q.size() !== DEPTH + 1) begin n_bad++;
            $display("FAIL full_issue: got %0d differing issues, %0d beats want 0/%0d", issue_diffs(), exp_q.size(), DEPTH + 1); end
    endtask

    task automatic test_empty_last();
        bit seen;
        start_run();
        send_beat(16'h1234, 4'b0000, make_msg(4'b1111), 1'b1);
        wait_done(seen);
        n_cmp++; if (!seen || match !== 1'b0 || obs_q.size() !== 0 || err !== 1'b0) begin n_bad++;
            $display("FAIL empty_last: got done %0d match %b issued %0d err %b want 1/0/0/0", seen, match, obs_q.size(), err); end
    endtask

    task automatic test_err_reset();
        bit seen;
        int unsigned d0;
        start_run();
        inject_mask = 4'b0010; inject_req++;
        repeat (3) @(negedge clk);
        n_cmp++; if (err !== 1'b1 || busy !== 1'b1) begin n_bad++;
            $display("FAIL err_empty: got err %b busy %b want 1/1", err, busy); end
        start = 1'b1; @(negedge clk); start = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL start_ignored: got err %b want 1", err); end
        stall = 1'b1;
        send_beat(16'h0200, 4'b1111, make_msg(4'b0001), 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++;
            $display("FAIL drain_wait: got busy %b done %b want 1/0", busy, done); end
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        n_cmp++; if ({busy, done, match, err, cand_ready, core_valid, match_pos, match_lane} !== '0) begin n_bad++;
            $display("FAIL midrun_reset: got busy %b done %b match %b err %b rdy %b cv %b pos %h lane %0d want all 0",
                     busy, done, match, err, cand_ready, core_valid, match_pos, match_lane); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (done_cnt !== d0) begin n_bad++;
            $display("FAIL reset_no_done: got %0d pulses want 0", done_cnt - d0); end
        start_run();
        send_beat(16'h0040, 4'b1111, make_msg(4'b0010), 1'b1);
        wait_done(seen);
        n_cmp++; if (!seen || match !== 1'b1 || match_pos !== 16'h0041 || match_lane !== 2'd1 || err !== 1'b0) begin n_bad++;
            $display("FAIL post_reset_run: got done %0d %b/%h/%0d err %b want 1 1/0041/1 0", seen, match, match_pos, match_lane, err); end
    endtask

    task automatic test_back_to_back();
        bit seen, ehit;
        logic [PW-1:0] epos, p;
        logic [1:0] elane;
        int nb;
        jitter = 1'b1;
        for (int r = 0; r < 6; r++) begin
            start_run();
            nb = $urandom_range(5, 20);
            p  = PW'($urandom);
            for (int b = 0; b < nb; b++) begin
                send_beat(p, 4'($urandom_range(0, 15)),
                          make_msg(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0), b == nb - 1);
                p = p + PW'(4);
            end
            wait_done(seen);
            model_hit(ehit, epos, elane);
            n_cmp++; if (!seen || match !== ehit || (ehit && (match_pos !== epos || match_lane !== elane))) begin n_bad++;
                $display("FAIL b2b_match run %0d: got done %0d %b/%h/%0d want %b/%h/%0d", r, seen, match, match_pos, match_lane, ehit, epos, elane); end
            n_cmp++; if (issue_diffs() !== 0 || err !== 1'b0) begin n_bad++;
                $display("FAIL b2b_issue run %0d: got %0d differing issues err %b want 0/0", r, issue_diffs(), err); end
        end
        jitter = 1'b0;
    endtask

    initial begin
        start = 1'b0; cand_valid = 1'b0; cand_msg = '0; cand_mask = '0; cand_pos = '0; cand_last = 1'b0;
        target = {$urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_single_hit();
        test_first_hit();
        test_wrap();
        test_fifo_full();
        test_empty_last();
        test_err_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
